// File: rtl/query_patch_aggregator_pkg.sv
// Shared query-buffer package: the patch aggregator's FSM encoding and its default geometry.
package query_patch_aggregator_pkg;

  localparam int QPA_WORD_WIDTH      = 11;
  localparam int QPA_WORDS_PER_PATCH = 5;
  localparam int QPA_DATA_WIDTH      = QPA_WORD_WIDTH * QPA_WORDS_PER_PATCH;
  localparam int QPA_ADDR_WIDTH      = 7;
  localparam int QPA_NUM_PATCHES     = 128;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } qpa_state_e;

endpackage

// File: rtl/query_patch_aggregator.sv
// Packs WORDS_PER_PATCH incoming query words into one patch (first word in the LSBs)
// and strobes each finished patch into the query row buffer, NUM_PATCHES per load.
module query_patch_aggregator #(
  parameter int WORD_WIDTH      = query_patch_aggregator_pkg::QPA_WORD_WIDTH,
  parameter int WORDS_PER_PATCH = query_patch_aggregator_pkg::QPA_WORDS_PER_PATCH,
  parameter int DATA_WIDTH      = query_patch_aggregator_pkg::QPA_DATA_WIDTH,
  parameter int ADDR_WIDTH      = query_patch_aggregator_pkg::QPA_ADDR_WIDTH,
  parameter int NUM_PATCHES     = query_patch_aggregator_pkg::QPA_NUM_PATCHES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  fsm_enable,
  input  logic                  io_valid,
  input  logic [WORD_WIDTH-1:0] io_data,
  output logic                  io_ready,
  output logic                  sender_enable,
  output logic [DATA_WIDTH-1:0] sender_data,
  output logic [ADDR_WIDTH:0]   patch_count,
  output logic                  done
);
  import query_patch_aggregator_pkg::*;

  localparam int IDX_W = (WORDS_PER_PATCH > 1) ? $clog2(WORDS_PER_PATCH) : 1;
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS_PER_PATCH - 1);
  localparam logic [CNT_W-1:0] COUNT_MAX = CNT_W'(NUM_PATCHES);

  qpa_state_e            state;
  logic [IDX_W-1:0]      word_idx;
  logic [DATA_WIDTH-1:0] patch_buf;
  logic [DATA_WIDTH-1:0] next_patch;
  logic                  accept;
  logic                  last_word;

  assign io_ready  = (state == ST_COLLECT) && fsm_enable;
  assign accept    = io_valid && io_ready;
  assign last_word = (word_idx == LAST_IDX);

  // NOTE: next_patch is defaulted before the loop so every path assigns it and no latch is inferred.
  always_comb begin
    next_patch = patch_buf;
    for (int k = 0; k < WORDS_PER_PATCH; k++) begin
      if (word_idx == IDX_W'(k)) begin
        next_patch[k*WORD_WIDTH +: WORD_WIDTH] = io_data;
      end
    end
  end

  // NOTE: the partial-patch register needs no reset: word_idx restarts at 0 and every
  // slot is rewritten before a patch is emitted, so stale contents never reach sender_data.
  always_ff @(posedge clk) begin
    if (accept) begin
      patch_buf <= next_patch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      word_idx      <= '0;
      patch_count   <= '0;
      sender_enable <= 1'b0;
      sender_data   <= '0;
      done          <= 1'b0;
    end else begin
      sender_enable <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_COLLECT;
            word_idx    <= '0;
            patch_count <= '0;
          end
        end
        ST_COLLECT: begin
          if (accept) begin
            if (last_word) begin
              word_idx      <= '0;
              sender_enable <= 1'b1;
              sender_data   <= next_patch;
              if (patch_count != COUNT_MAX) begin
                patch_count <= patch_count + CNT_W'(1);
              end
            end else begin
              word_idx <= word_idx + IDX_W'(1);
            end
          end
          // The load ends once the final patch strobe has been presented.
          if (sender_enable && (patch_count == COUNT_MAX)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (start) begin
            state       <= ST_COLLECT;
            done        <= 1'b0;
            word_idx    <= '0;
            patch_count <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/query_patch_aggregator.md
QUERY_PATCH_AGGREGATOR -- requirements
Module: query_patch_aggregator

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 11: width of one I/O word (one patch element).
REQ-002 SHALL have parameter WORDS_PER_PATCH, default 5: number of I/O words packed into one patch.
REQ-003 SHALL have parameter DATA_WIDTH, default 55: patch width; must equal WORD_WIDTH*WORDS_PER_PATCH.
REQ-004 SHALL have parameter ADDR_WIDTH, default 7, and parameter NUM_PATCHES, default 128: patches per load, at most 2^ADDR_WIDTH.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: one-cycle pulse that begins a load.
REQ-008 SHALL have port fsm_enable, input, 1: top FSM is in the query I/O phase.
REQ-009 SHALL have ports io_valid (input, 1) and io_data (input, WORD_WIDTH): incoming word and its qualifier.
REQ-010 SHALL have port io_ready, output, 1: block accepts a word this cycle.
REQ-011 SHALL have ports sender_enable (output, 1) and sender_data (output, DATA_WIDTH): patch write strobe and data to the query row buffer.
REQ-012 SHALL have port patch_count, output, ADDR_WIDTH+1: patches emitted since start.
REQ-013 SHALL have port done, output, 1: load complete.

Function
REQ-014 SHALL implement FSM states IDLE, COLLECT, DONE.
REQ-015 IDLE->COLLECT on start; COLLECT->DONE on the cycle the NUM_PATCHES-th patch is emitted; DONE->COLLECT on start; no other transitions.
REQ-016 io_ready SHALL be high only when state==COLLECT and fsm_enable==1 (combinational).
REQ-017 A word SHALL be accepted iff io_valid && io_ready at posedge.
REQ-018 Word k (0-based) of a patch SHALL occupy sender_data bits [k*WORD_WIDTH +: WORD_WIDTH]; the first word goes in the LSBs.
REQ-019 A word-index counter SHALL count 0..WORDS_PER_PATCH-1 and wrap to 0 on accepting the last word.
REQ-020 When the last word is accepted, sender_data SHALL be updated and sender_enable SHALL be high for exactly the next cycle (latency 1).
REQ-021 sender_data SHALL hold its last value when sender_enable is low.
REQ-022 Back-to-back acceptance SHALL continue with no bubble between patches; sender_enable may be high in consecutive patch-boundary cycles only if WORDS_PER_PATCH==1.
REQ-023 patch_count SHALL increment by 1 in the cycle sender_enable is asserted and SHALL saturate at NUM_PATCHES.
REQ-024 done SHALL be high exactly while state==DONE.
REQ-025 fsm_enable low mid-patch SHALL stall: partial words and the index are retained, and collection resumes when fsm_enable returns.
REQ-026 start while in COLLECT SHALL be ignored.
REQ-027 start from IDLE or DONE SHALL clear the word index and patch_count.
REQ-028 io_valid with io_ready low SHALL be dropped and nothing recorded; the sender must hold its data.

Reset
REQ-029 On rst_n low, immediately: state=IDLE, word index=0, patch_count=0, sender_enable=0, sender_data=0, done=0, io_ready=0.
REQ-030 Reset asserted mid-patch or mid-load SHALL discard partial data; no sender_enable pulse after release.

Structure
REQ-031 The FSM state encoding and the default WORD_WIDTH, WORDS_PER_PATCH, DATA_WIDTH, ADDR_WIDTH and NUM_PATCHES SHALL live in the shared project package used by the query buffers.
REQ-032 The block SHALL be flat with no sub-modules; it drives the row buffer's sender_enable/sender_data directly.

Verification
REQ-033 Reset, start, words 1,2,3,4,5 on consecutive cycles -> one-cycle sender_enable the cycle after word 5; sender_data={5,4,3,2,1} in 11-bit fields; patch_count=1.
REQ-034 NUM_PATCHES=4, 20 words streamed continuously -> exactly 4 sender_enable pulses; done=1 the cycle after the 4th pulse; io_ready=0 afterwards.
REQ-035 fsm_enable dropped after word 3 for 10 cycles with io_valid held high -> io_ready=0 and no acceptance; words 4 and 5 complete the same patch after re-enable.
REQ-036 rst_n pulsed low after word 2 -> outputs zero immediately; a new start plus 5 words gives a patch containing only the new words.
REQ-037 start pulsed during COLLECT after word 2 -> ignored; the patch completes normally with patch_count=1.
REQ-038 Random io_valid gaps over 128 patches -> data and order match a reference model; done asserted; patch_count=128.
